// File: rtl/rgb2ycbcr_pipe.sv
// Pipelined RGB -> YCbCr converter (JFIF full range or BT.601 studio range per pixel).
// Three lanes (Y, Cb, Cr) share one 3-stage timing pipe so data and syncs never skew.

module rgb2ycbcr_lane #(
  parameter int DATA_W     = 8,
  parameter int LANE       = 0,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   mode,
  input  logic                   mode_s1,
  input  logic                   mode_s2,
  input  logic                   de_s2,
  input  logic [2:0][DATA_W-1:0] pix,
  output logic [DATA_W-1:0]      res
);
  localparam int PW = DATA_W + 11;
  localparam int SW = DATA_W + 12;
  localparam int SC = DATA_W - 8;

  localparam int CF0 [3][3] = '{'{77, 150, 29}, '{-43, -85, 128}, '{128, -107, -21}};
  localparam int CF1 [3][3] = '{'{66, 129, 25}, '{-38, -74, 112}, '{112, -94, -18}};
  localparam int OFS0 = (LANE == 0) ? 0 : 128;
  localparam int OFS1 = (LANE == 0) ? 16 : 128;
  localparam int HI1  = (LANE == 0) ? 235 : 240;

  logic [2:0][PW-1:0]     prod_d, prod_q;
  logic signed [SW-1:0]   sum_d, sum_q, q, lo, hi;
  logic [DATA_W-1:0]      res_d;
  int                     c;

  // Products wrap modulo 2^PW; the true values fit, so the bits are exact two's complement.
  always_comb begin
    prod_d = '0;
    c      = 0;
    for (int i = 0; i < 3; i++) begin
      c         = mode ? CF1[LANE][i] : CF0[LANE][i];
      prod_d[i] = PW'(c) * PW'({1'b0, pix[i]});
    end
  end

  always_comb begin
    sum_d = SW'($signed(prod_q[0])) + SW'($signed(prod_q[1])) + SW'($signed(prod_q[2]))
          + (SW'(mode_s1 ? OFS1 : OFS0) <<< DATA_W) + SW'(128);
  end

  always_comb begin
    q     = sum_q >>> 8;
    lo    = mode_s2 ? SW'(16 << SC) : '0;
    hi    = mode_s2 ? SW'(HI1 << SC) : SW'((1 << DATA_W) - 1);
    res_d = q[DATA_W-1:0];
    if (q < lo)      res_d = lo[DATA_W-1:0];
    else if (q > hi) res_d = hi[DATA_W-1:0];
    if (BLANK_ZERO && !de_s2) res_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      sum_q  <= '0;
      res    <= '0;
    end else if (ce) begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
      res    <= res_d;
    end
  end
endmodule

module rgb2ycbcr_pipe #(
  parameter int DATA_W     = 8,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              mode,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  output logic [DATA_W-1:0] Y,
  output logic [DATA_W-1:0] Cb,
  output logic [DATA_W-1:0] Cr,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out
);
  typedef struct packed {
    logic mode;
    logic de;
    logic hsync;
    logic vsync;
  } tim_t;

  tim_t                   tim_in;
  tim_t [2:1]             vld_pipe;
  logic [2:0]             sync_q;
  logic [2:0][DATA_W-1:0] rgb, ycc;

  assign tim_in = '{mode: mode, de: de_in, hsync: hsync_in, vsync: vsync_in};
  assign rgb    = {blue, green, red};

  // Mode is only needed up to the clamp decision, so the last stage keeps just the syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      sync_q   <= '0;
    end else if (ce) begin
      vld_pipe <= {vld_pipe[1], tim_in};
      sync_q   <= {vld_pipe[2].de, vld_pipe[2].hsync, vld_pipe[2].vsync};
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_lane
    rgb2ycbcr_lane #(
      .DATA_W    (DATA_W),
      .LANE      (g),
      .BLANK_ZERO(BLANK_ZERO)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .mode   (mode),
      .mode_s1(vld_pipe[1].mode),
      .mode_s2(vld_pipe[2].mode),
      .de_s2  (vld_pipe[2].de),
      .pix    (rgb),
      .res    (ycc[g])
    );
  end

  assign Y         = ycc[0];
  assign Cb        = ycc[1];
  assign Cr        = ycc[2];
  assign de_out    = sync_q[2];
  assign hsync_out = sync_q[1];
  assign vsync_out = sync_q[0];
endmodule
